// File: rtl/etapa_ex_mem_pipe_if.sv
// EX/MEM pipeline register bus: EX-side inputs, hazard controls,
// MEM-side outputs and debug counters.
interface etapa_ex_mem_pipe_if #(
  parameter int NBITS    = 32,
  parameter int REGS     = 5,
  parameter int CTRLM_W  = 5,
  parameter int CTRLWB_W = 5,
  parameter int CNT_W    = 16
);
  logic                i_stall;
  logic                i_flush;
  logic                i_valid;
  logic [NBITS-1:0]    i_PC4;
  logic [NBITS-1:0]    i_PCBranch;
  logic [NBITS-1:0]    i_Instruction;
  logic                i_Cero;
  logic [NBITS-1:0]    i_ALU;
  logic [NBITS-1:0]    i_Registro2;
  logic [REGS-1:0]     i_RegistroDestino;
  logic [CTRLM_W-1:0]  i_CtrlM;
  logic [CTRLWB_W-1:0] i_CtrlWB;

  logic                o_valid;
  logic [NBITS-1:0]    o_PC4;
  logic [NBITS-1:0]    o_PCBranch;
  logic [NBITS-1:0]    o_Instruction;
  logic                o_Cero;
  logic [NBITS-1:0]    o_ALU;
  logic [NBITS-1:0]    o_Registro2;
  logic [REGS-1:0]     o_RegistroDestino;
  logic [CTRLM_W-1:0]  o_CtrlM;
  logic [CTRLWB_W-1:0] o_CtrlWB;
  logic [CNT_W-1:0]    o_stall_count;
  logic [CNT_W-1:0]    o_flush_count;

  modport master (
    output i_stall, i_flush, i_valid,
    output i_PC4, i_PCBranch, i_Instruction,
    output i_Cero, i_ALU, i_Registro2,
    output i_RegistroDestino, i_CtrlM, i_CtrlWB,
    input  o_valid, o_PC4, o_PCBranch,
    input  o_Instruction, o_Cero, o_ALU,
    input  o_Registro2, o_RegistroDestino,
    input  o_CtrlM, o_CtrlWB,
    input  o_stall_count, o_flush_count
  );

  modport slave (
    input  i_stall, i_flush, i_valid,
    input  i_PC4, i_PCBranch, i_Instruction,
    input  i_Cero, i_ALU, i_Registro2,
    input  i_RegistroDestino, i_CtrlM, i_CtrlWB,
    output o_valid, o_PC4, o_PCBranch,
    output o_Instruction, o_Cero, o_ALU,
    output o_Registro2, o_RegistroDestino,
    output o_CtrlM, o_CtrlWB,
    output o_stall_count, o_flush_count
  );
endinterface

// File: rtl/etapa_ex_mem_pipe.sv
// Parametrised EX/MEM register with stall/flush, falling-edge capture.
// Optional debug counters enabled by EX_MEM_STATS_EN.
module etapa_ex_mem_pipe #(
  parameter int NBITS    = 32,
  parameter int REGS     = 5,
  parameter int CTRLM_W  = 5,
  parameter int CTRLWB_W = 5,
  parameter int STAGES   = 1,
  parameter int CNT_W    = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  etapa_ex_mem_pipe_if.slave     bus
);

  typedef struct packed {
    logic                valid;
    logic [NBITS-1:0]    pc4;
    logic [NBITS-1:0]    pcb;
    logic [NBITS-1:0]    ins;
    logic                cero;
    logic [NBITS-1:0]    alu;
    logic [NBITS-1:0]    r2;
    logic [REGS-1:0]     rd;
    logic [CTRLM_W-1:0]  m;
    logic [CTRLWB_W-1:0] wb;
  } stage_t;

  stage_t st_q [STAGES];
  stage_t in_d;
  logic   bubble;
  logic   load0;

  assign bubble = bus.i_flush | ~bus.i_valid;
  assign load0  = bus.i_flush | ~bus.i_stall;

  // Control is zeroed whenever the entry is not valid.
  always_comb begin
    in_d       = '0;
    in_d.valid = ~bubble;
    in_d.pc4   = bus.i_PC4;
    in_d.pcb   = bus.i_PCBranch;
    in_d.ins   = bus.i_Instruction;
    in_d.cero  = bus.i_Cero;
    in_d.alu   = bus.i_ALU;
    in_d.r2    = bus.i_Registro2;
    in_d.rd    = bus.i_RegistroDestino;
    if (!bubble) begin
      in_d.m  = bus.i_CtrlM;
      in_d.wb = bus.i_CtrlWB;
    end
  end

  always_ff @(negedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < STAGES; k++)
        st_q[k] <= '0;
    end else begin
      if (load0)
        st_q[0] <= in_d;
      if (!bus.i_stall)
        for (int k = 1; k < STAGES; k++)
          st_q[k] <= st_q[k-1];
    end
  end

  assign bus.o_valid           = st_q[STAGES-1].valid;
  assign bus.o_PC4             = st_q[STAGES-1].pc4;
  assign bus.o_PCBranch        = st_q[STAGES-1].pcb;
  assign bus.o_Instruction     = st_q[STAGES-1].ins;
  assign bus.o_Cero            = st_q[STAGES-1].cero;
  assign bus.o_ALU             = st_q[STAGES-1].alu;
  assign bus.o_Registro2       = st_q[STAGES-1].r2;
  assign bus.o_RegistroDestino = st_q[STAGES-1].rd;
  assign bus.o_CtrlM           = st_q[STAGES-1].m;
  assign bus.o_CtrlWB          = st_q[STAGES-1].wb;

`ifdef EX_MEM_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(negedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bus.i_stall && !bus.i_flush && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (bus.i_flush && !(&flush_cnt_q))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.o_stall_count = stall_cnt_q;
  assign bus.o_flush_count = flush_cnt_q;
`else
  assign bus.o_stall_count = {CNT_W{1'b0}};
  assign bus.o_flush_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_etapa_ex_mem_pipe.sv
// Directed bench for etapa_ex_mem_pipe: depth 1, depth 3 and
// a narrow-counter instance sharing one clock and reset.
module tb_etapa_ex_mem_pipe;

`ifdef EX_MEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  etapa_ex_mem_pipe_if #(.CNT_W(16)) b1 ();
  etapa_ex_mem_pipe_if #(.CNT_W(16)) b3 ();
  etapa_ex_mem_pipe_if #(.CNT_W(4))  bs ();

  etapa_ex_mem_pipe #(.STAGES(1), .CNT_W(16)) dut1 (
    .i_clk(clk), .i_reset(rst), .bus(b1)
  );
  etapa_ex_mem_pipe #(.STAGES(3), .CNT_W(16)) dut3 (
    .i_clk(clk), .i_reset(rst), .bus(b3)
  );
  etapa_ex_mem_pipe #(.STAGES(1), .CNT_W(4)) duts (
    .i_clk(clk), .i_reset(rst), .bus(bs)
  );

  // Advance one falling edge; inputs change and outputs are
  // sampled 1 time unit after it.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic test_reset();
    b1.i_valid = 1'b1; b1.i_ALU = 32'h1234;
    b1.i_Instruction = 32'hDEAD_BEEF;
    b1.i_CtrlWB = 5'b01000; b1.i_CtrlM = 5'b00100;
    b1.i_RegistroDestino = 5'd7;
    step();
    chk("rst_pre_valid", 32'(b1.o_valid), 32'd1);
    chk("rst_pre_alu", b1.o_ALU, 32'h1234);
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(b1.o_valid), 32'd0);
    chk("rst_alu", b1.o_ALU, 32'd0);
    chk("rst_ins", b1.o_Instruction, 32'd0);
    chk("rst_wb", 32'(b1.o_CtrlWB), 32'd0);
    chk("rst_m", 32'(b1.o_CtrlM), 32'd0);
    chk("rst_rd", 32'(b1.o_RegistroDestino), 32'd0);
    chk("rst_scnt", 32'(b1.o_stall_count), 32'd0);
    #1 rst = 1'b0;
  endtask

  task automatic test_pass();
    b1.i_valid = 1'b1; b1.i_ALU = 32'h0000_00A5;
    b1.i_CtrlWB = 5'b01000; b1.i_CtrlM = 5'b00000;
    b1.i_PC4 = 32'h104; b1.i_Cero = 1'b1;
    step();
    chk("pass_alu", b1.o_ALU, 32'h0000_00A5);
    chk("pass_wb", 32'(b1.o_CtrlWB), 32'(5'b01000));
    chk("pass_valid", 32'(b1.o_valid), 32'd1);
    chk("pass_pc4", b1.o_PC4, 32'h104);
    chk("pass_cero", 32'(b1.o_Cero), 32'd1);
    b1.i_valid = 1'b0; b1.i_CtrlM = 5'b01100;
    b1.i_ALU = 32'h55;
    step();
    chk("inv_valid", 32'(b1.o_valid), 32'd0);
    chk("inv_m", 32'(b1.o_CtrlM), 32'd0);
    chk("inv_wb", 32'(b1.o_CtrlWB), 32'd0);
    chk("inv_alu", b1.o_ALU, 32'h55);
  endtask

  task automatic test_stall();
    b1.i_valid = 1'b1; b1.i_CtrlM = 5'b00000;
    b1.i_ALU = 32'hA;
    step();
    b1.i_stall = 1'b1; b1.i_ALU = 32'hB;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold", b1.o_ALU, 32'hA);
    end
    chk("stall_cnt", 32'(b1.o_stall_count), STATS ? 32'd3 : 32'd0);
    b1.i_stall = 1'b0;
    step();
    chk("stall_rel", b1.o_ALU, 32'hB);
  endtask

  task automatic test_flush_stall();
    b1.i_valid = 1'b1; b1.i_flush = 1'b1; b1.i_stall = 1'b1;
    b1.i_CtrlM = 5'b01100; b1.i_CtrlWB = 5'b01000;
    b1.i_ALU = 32'hC;
    step();
    chk("fs_valid", 32'(b1.o_valid), 32'd0);
    chk("fs_m", 32'(b1.o_CtrlM), 32'd0);
    chk("fs_wb", 32'(b1.o_CtrlWB), 32'd0);
    chk("fs_alu", b1.o_ALU, 32'hC);
    chk("fs_fcnt", 32'(b1.o_flush_count), STATS ? 32'd1 : 32'd0);
    chk("fs_scnt", 32'(b1.o_stall_count), STATS ? 32'd3 : 32'd0);
    b1.i_flush = 1'b0; b1.i_stall = 1'b0;
    step();
    chk("fs_after_m", 32'(b1.o_CtrlM), 32'(5'b01100));
  endtask

  task automatic test_depth();
    b3.i_valid = 1'b1; b3.i_CtrlWB = 5'b01000;
    b3.i_ALU = 32'd1; step();
    b3.i_ALU = 32'd2; step();
    chk("dep_e2_valid", 32'(b3.o_valid), 32'd0);
    b3.i_ALU = 32'd3; step();
    chk("dep_e3", b3.o_ALU, 32'd1);
    chk("dep_e3_valid", 32'(b3.o_valid), 32'd1);
    b3.i_stall = 1'b1; b3.i_ALU = 32'd9;
    step();
    chk("dep_st1", b3.o_ALU, 32'd1);
    step();
    chk("dep_st2", b3.o_ALU, 32'd1);
    b3.i_stall = 1'b0; b3.i_ALU = 32'd4;
    step();
    chk("dep_e4", b3.o_ALU, 32'd2);
    b3.i_flush = 1'b1; b3.i_ALU = 32'd5;
    step();
    chk("dep_e5", b3.o_ALU, 32'd3);
    b3.i_flush = 1'b0;
    step();
    chk("dep_e6", b3.o_ALU, 32'd4);
    step();
    chk("dep_bub_valid", 32'(b3.o_valid), 32'd0);
    chk("dep_bub_wb", 32'(b3.o_CtrlWB), 32'd0);
  endtask

  task automatic test_saturation();
    bs.i_stall = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("sat_scnt", 32'(bs.o_stall_count), STATS ? 32'd15 : 32'd0);
    chk("sat_fcnt", 32'(bs.o_flush_count), 32'd0);
    bs.i_stall = 1'b0; bs.i_flush = 1'b1;
    for (int i = 0; i < 17; i++) step();
    chk("sat_fcnt2", 32'(bs.o_flush_count), STATS ? 32'd15 : 32'd0);
    chk("sat_scnt2", 32'(bs.o_stall_count), STATS ? 32'd15 : 32'd0);
    bs.i_flush = 1'b0;
  endtask

  initial begin
    b1.i_stall = 0; b1.i_flush = 0; b1.i_valid = 0;
    b1.i_PC4 = 0; b1.i_PCBranch = 0; b1.i_Instruction = 0;
    b1.i_Cero = 0; b1.i_ALU = 0; b1.i_Registro2 = 0;
    b1.i_RegistroDestino = 0; b1.i_CtrlM = 0; b1.i_CtrlWB = 0;
    b3.i_stall = 0; b3.i_flush = 0; b3.i_valid = 0;
    b3.i_PC4 = 0; b3.i_PCBranch = 0; b3.i_Instruction = 0;
    b3.i_Cero = 0; b3.i_ALU = 0; b3.i_Registro2 = 0;
    b3.i_RegistroDestino = 0; b3.i_CtrlM = 0; b3.i_CtrlWB = 0;
    bs.i_stall = 0; bs.i_flush = 0; bs.i_valid = 0;
    bs.i_PC4 = 0; bs.i_PCBranch = 0; bs.i_Instruction = 0;
    bs.i_Cero = 0; bs.i_ALU = 0; bs.i_Registro2 = 0;
    bs.i_RegistroDestino = 0; bs.i_CtrlM = 0; bs.i_CtrlWB = 0;
    #1 rst = 1'b1;
    #3 rst = 1'b0;
    test_reset();
    test_pass();
    test_stall();
    test_flush_stall();
    test_depth();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
